ifu_prefetch: RTL and testbench
===============================

Name: ifu_prefetch

Overview:
Parametrised instruction-fetch front end for the pipelined core. It replaces the single-register fetch stage with a decoupled prefetch queue and valid/ready handshakes on both sides. Issues sequential fetch requests to instruction memory and buffers in-order responses in a FIFO. Supports redirect (jump/branch) with discard of stale in-flight responses, and presents {pc, instr, snxt_pc} to decode.

Parameters:
XLEN, 64, address/PC width
RESET_PC, 64'h80000000, fetch PC after reset
DEPTH, 4, queue entries and maximum outstanding requests; power of 2, >=2
CW, $clog2(DEPTH)+1, counter width (derived, not overridable)

Ports:
clk  in  1  clock, all state on rising edge
rstn  in  1  reset; asynchronous, active-low
redirect_en  in  1  jump/branch taken; flush and refetch
redirect_pc  in  XLEN  new fetch target
imem_req_valid  out  1  fetch request valid
imem_req_ready  in  1  memory accepts request
imem_req_addr  out  XLEN  fetch address
imem_rsp_valid  in  1  response valid; in order, always accepted
imem_rsp_instr  in  32  fetched instruction
out_valid  out  1  head entry holds a returned instruction
out_ready  in  1  decode accepts head
out_pc  out  XLEN  head PC
out_instr  out  32  head instruction
out_snxt_pc  out  XLEN  head PC + 4 (mod 2^XLEN)
occupancy  out  CW  allocated queue entries

Behaviour:
- Reset (async assert, sync-release use): fetch_pc=RESET_PC; queue empty; outstanding=0; drop_cnt=0; out_valid=0; imem_req_valid=0; occupancy=0; out_pc/out_instr/out_snxt_pc=0.
- Entry allocated at request acceptance (req_valid & req_ready), storing fetch_pc; fetch_pc += 4; outstanding += 1.
- imem_req_valid = !redirect_en && occupancy < DEPTH && outstanding < DEPTH. imem_req_addr = fetch_pc.
- Response: if drop_cnt > 0, discard and decrement drop_cnt; otherwise fill the oldest unfilled entry with instr. Every response decrements outstanding.
- out_valid = head allocated and filled. Outputs are driven from the head entry registers; no combinational path from imem_rsp_* to out_*. Minimum latency: response in cycle N -> out_valid in cycle N+1.
- Dequeue on out_valid & out_ready & !redirect_en; occupancy decrements.
- Simultaneous alloc+dequeue: occupancy unchanged. Full queue (occupancy=DEPTH): no request; dequeue reopens requests the following cycle.
- Redirect (redirect_en=1): all entries invalidated; occupancy=0 next cycle; fetch_pc=redirect_pc; no request issued and no dequeue in that cycle. drop_cnt = outstanding - (valid, non-dropped imem_rsp_valid this cycle ? 1 : 0) + existing drop_cnt contribution. Equivalently, drop_cnt_next = outstanding_next, so every response belonging to pre-redirect requests is discarded. Requests may resume the next cycle while drop_cnt > 0, within the outstanding limit.
- Redirect on consecutive cycles: the last one wins; drop_cnt still tracks every outstanding request.
- Wrap-around: fetch_pc and snxt_pc wrap modulo 2^XLEN. Queue pointers wrap modulo DEPTH. redirect_pc alignment is the caller's responsibility; it is used unmodified.
- Reset mid-operation: all state cleared immediately, including drop_cnt. Memory must not deliver pre-reset responses after reset release.

Test Plan:
- Reset -> fetch from 0x80000000; out_valid=0, occupancy=0; first request addr 0x80000000.
- Streaming, zero-latency-plus-1 memory, out_ready=1 -> out_pc 0x80000000, 0x80000004, ... one per cycle; out_snxt_pc = out_pc+4; instr matches memory.
- out_ready=0, DEPTH=4 -> exactly 4 requests (0x80000000..0x8000000C); req_valid low while occupancy=4. A single out_ready pulse -> one dequeue and one new request to 0x80000010.
- Redirect to 0x80001000 with 3 requests outstanding -> the 3 late responses are dropped; first out_pc=0x80001000 with the correct instr.
- Redirect in the same cycle as imem_rsp_valid and out_valid&out_ready -> no dequeue; that response is dropped; drop_cnt = outstanding-1; the queue is empty next cycle.
- Assert rstn low asynchronously mid-stream (between clock edges) -> outputs zero immediately; after release, fetch restarts at 0x80000000.

Source files
------------

// File: rtl/ifu_prefetch.sv
// Instruction-fetch prefetch queue: sequential fetch requests, in-order
// response buffering, redirect flush with stale-response discard.
module ifu_prefetch #(
  parameter int              XLEN     = 64,
  parameter logic [XLEN-1:0] RESET_PC = 64'h8000_0000,
  parameter int              DEPTH    = 4
) (
  input  logic                   clk,
  input  logic                   rstn,
  input  logic                   redirect_en,
  input  logic [XLEN-1:0]        redirect_pc,
  output logic                   imem_req_valid,
  input  logic                   imem_req_ready,
  output logic [XLEN-1:0]        imem_req_addr,
  input  logic                   imem_rsp_valid,
  input  logic [31:0]            imem_rsp_instr,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [XLEN-1:0]        out_pc,
  output logic [31:0]            out_instr,
  output logic [XLEN-1:0]        out_snxt_pc,
  output logic [$clog2(DEPTH):0] occupancy
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH) + 1;

  logic [XLEN-1:0] r_pc    [DEPTH];
  logic [XLEN-1:0] r_nxt   [DEPTH];
  logic [31:0]     r_instr [DEPTH];
  logic [DEPTH-1:0] r_filled;

  logic [AW-1:0]   r_head;
  logic [AW-1:0]   r_tail;
  logic [AW-1:0]   r_fill;
  logic [CW-1:0]   r_occ;
  logic [CW-1:0]   r_outst;
  logic [CW-1:0]   r_drop;
  logic [XLEN-1:0] r_fetch_pc;
  logic            r_run;

  logic            w_acc;
  logic            w_keep;
  logic            w_deq;
  logic [CW-1:0]   w_outst_nxt;

  assign imem_req_valid = r_run & ~redirect_en
                        & (r_occ < CW'(DEPTH))
                        & (r_outst < CW'(DEPTH));
  assign imem_req_addr  = r_fetch_pc;

  assign w_acc  = imem_req_valid & imem_req_ready;
  assign w_keep = imem_rsp_valid & (r_drop == '0);
  assign w_deq  = out_valid & out_ready & ~redirect_en;

  assign w_outst_nxt = r_outst + CW'(w_acc)
                     - CW'(imem_rsp_valid);

  assign out_valid   = r_filled[r_head];
  assign out_pc      = r_pc[r_head];
  assign out_snxt_pc = r_nxt[r_head];
  assign out_instr   = r_instr[r_head];
  assign occupancy   = r_occ;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      for (int i = 0; i < DEPTH; i++) begin
        r_pc[i]    <= '0;
        r_nxt[i]   <= '0;
        r_instr[i] <= '0;
      end
      r_filled   <= '0;
      r_head     <= '0;
      r_tail     <= '0;
      r_fill     <= '0;
      r_occ      <= '0;
      r_outst    <= '0;
      r_drop     <= '0;
      r_fetch_pc <= RESET_PC;
      r_run      <= 1'b0;
    end else begin
      r_run   <= 1'b1;
      r_outst <= w_outst_nxt;
      if (imem_rsp_valid && (r_drop != '0))
        r_drop <= r_drop - CW'(1);
      if (redirect_en) begin
        // every still-outstanding response predates the redirect
        r_drop     <= w_outst_nxt;
        r_fetch_pc <= redirect_pc;
        r_occ      <= '0;
        r_head     <= '0;
        r_tail     <= '0;
        r_fill     <= '0;
        r_filled   <= '0;
      end else begin
        if (w_acc) begin
          r_pc[r_tail]  <= r_fetch_pc;
          r_nxt[r_tail] <= r_fetch_pc + XLEN'(4);
          r_tail        <= r_tail + AW'(1);
          r_fetch_pc    <= r_fetch_pc + XLEN'(4);
        end
        if (w_keep) begin
          r_instr[r_fill]  <= imem_rsp_instr;
          r_filled[r_fill] <= 1'b1;
          r_fill           <= r_fill + AW'(1);
        end
        if (w_deq) begin
          r_filled[r_head] <= 1'b0;
          r_head           <= r_head + AW'(1);
        end
        r_occ <= r_occ + CW'(w_acc) - CW'(w_deq);
      end
    end
  end

endmodule

// File: tb/tb_ifu_prefetch.sv
// Directed bench for ifu_prefetch with an in-order,
// variable-latency instruction memory model.
module tb_ifu_prefetch;

  logic        clk = 1'b0;
  logic        rstn = 1'b0;
  logic        redirect_en = 1'b0;
  logic [63:0] redirect_pc = '0;
  logic        imem_req_valid;
  logic        imem_req_ready = 1'b1;
  logic [63:0] imem_req_addr;
  logic        imem_rsp_valid;
  logic [31:0] imem_rsp_instr;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [63:0] out_pc;
  logic [31:0] out_instr;
  logic [63:0] out_snxt_pc;
  logic [2:0]  occupancy;

  int checks = 0;
  int errors = 0;

  bit hold = 1'b0;
  int lat = 1;
  int cyc = 0;
  int acc_cnt = 0;
  logic [63:0] pq_a[$];
  int          pq_c[$];

  ifu_prefetch dut (
    .clk            (clk),
    .rstn           (rstn),
    .redirect_en    (redirect_en),
    .redirect_pc    (redirect_pc),
    .imem_req_valid (imem_req_valid),
    .imem_req_ready (imem_req_ready),
    .imem_req_addr  (imem_req_addr),
    .imem_rsp_valid (imem_rsp_valid),
    .imem_rsp_instr (imem_rsp_instr),
    .out_valid      (out_valid),
    .out_ready      (out_ready),
    .out_pc         (out_pc),
    .out_instr      (out_instr),
    .out_snxt_pc    (out_snxt_pc),
    .occupancy      (occupancy)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] mem_f(
    input logic [63:0] a);
    return a[31:0] ^ 32'h5EED_0013;
  endfunction

  // memory: answers each accepted request lat cycles later, in order
  always @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      pq_a.delete();
      pq_c.delete();
      acc_cnt = 0;
      imem_rsp_valid <= 1'b0;
      imem_rsp_instr <= '0;
    end else begin
      cyc = cyc + 1;
      if (imem_rsp_valid) begin
        void'(pq_a.pop_front());
        void'(pq_c.pop_front());
      end
      if (imem_req_valid && imem_req_ready) begin
        pq_a.push_back(imem_req_addr);
        pq_c.push_back(cyc);
        acc_cnt = acc_cnt + 1;
      end
      if (!hold && pq_a.size() > 0
          && (cyc - pq_c[0]) >= lat - 1) begin
        imem_rsp_valid <= 1'b1;
        imem_rsp_instr <= mem_f(pq_a[0]);
      end else begin
        imem_rsp_valid <= 1'b0;
      end
    end
  end

  task automatic chk(input string tag,
                     input logic [63:0] obs,
                     input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  // wait for a valid head, check it, then dequeue it
  task automatic expect_head(input string tag,
                             input logic [63:0] pc);
    logic [63:0] nxt;
    bit found;
    found = 1'b0;
    nxt = pc + 64'd4;
    for (int i = 0; i < 30; i++) begin
      if (out_valid) begin
        found = 1'b1;
        break;
      end
      @(negedge clk);
    end
    chk({tag, "_found"}, 64'(found), 64'd1);
    chk({tag, "_pc"}, out_pc, pc);
    chk({tag, "_instr"}, 64'(out_instr), 64'(mem_f(pc)));
    chk({tag, "_snxt"}, out_snxt_pc, nxt);
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
  endtask

  initial begin
    bit found;

    // reset state
    repeat (2) @(negedge clk);
    chk("rst_valid", 64'(out_valid), 64'd0);
    chk("rst_occ", 64'(occupancy), 64'd0);
    chk("rst_req", 64'(imem_req_valid), 64'd0);
    chk("rst_pc", out_pc, 64'd0);
    rstn = 1'b1;

    @(negedge clk);
    chk("first_req", 64'(imem_req_valid), 64'd1);
    chk("first_addr", imem_req_addr, 64'h8000_0000);

    // queue fills with out_ready low
    repeat (8) @(negedge clk);
    chk("full_occ", 64'(occupancy), 64'd4);
    chk("full_req", 64'(imem_req_valid), 64'd0);
    chk("full_acc", 64'(acc_cnt), 64'd4);
    chk("full_valid", 64'(out_valid), 64'd1);
    chk("full_pc", out_pc, 64'h8000_0000);
    chk("full_instr", 64'(out_instr),
        64'(mem_f(64'h8000_0000)));

    // one dequeue pulse reopens exactly one request
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    chk("pulse_occ", 64'(occupancy), 64'd3);
    chk("pulse_pc", out_pc, 64'h8000_0004);
    chk("pulse_req", 64'(imem_req_valid), 64'd1);
    chk("pulse_addr", imem_req_addr, 64'h8000_0010);
    @(negedge clk);
    chk("refill_occ", 64'(occupancy), 64'd4);
    chk("refill_req", 64'(imem_req_valid), 64'd0);
    chk("refill_acc", 64'(acc_cnt), 64'd5);

    // streaming, one instruction per cycle
    out_ready = 1'b1;
    for (int k = 0; k < 8; k++) begin
      logic [63:0] epc;
      epc = 64'h8000_0008 + 64'(4 * k);
      @(negedge clk);
      chk("strm_valid", 64'(out_valid), 64'd1);
      chk("strm_pc", out_pc, epc);
      chk("strm_snxt", out_snxt_pc, epc + 64'd4);
      chk("strm_instr", 64'(out_instr), 64'(mem_f(epc)));
    end

    // asynchronous reset between clock edges
    #2 rstn = 1'b0;
    #1;
    chk("arst_valid", 64'(out_valid), 64'd0);
    chk("arst_occ", 64'(occupancy), 64'd0);
    chk("arst_pc", out_pc, 64'd0);
    chk("arst_instr", 64'(out_instr), 64'd0);
    chk("arst_snxt", out_snxt_pc, 64'd0);
    chk("arst_req", 64'(imem_req_valid), 64'd0);
    out_ready = 1'b0;
    @(negedge clk);
    rstn = 1'b1;
    found = 1'b0;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      if (imem_req_valid) begin
        found = 1'b1;
        break;
      end
    end
    chk("arst_reqf", 64'(found), 64'd1);
    chk("arst_addr", imem_req_addr, 64'h8000_0000);
    expect_head("arst_h0", 64'h8000_0000);

    // redirect with 3 requests outstanding, responses held
    hold = 1'b1;
    @(negedge clk);
    rstn = 1'b0;
    @(negedge clk);
    rstn = 1'b1;
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      if (acc_cnt >= 3) break;
    end
    imem_req_ready = 1'b0;
    chk("rd3_acc", 64'(acc_cnt), 64'd3);
    redirect_en = 1'b1;
    redirect_pc = 64'h8000_1000;
    #1;
    chk("rd3_noreq", 64'(imem_req_valid), 64'd0);
    @(negedge clk);
    redirect_en = 1'b0;
    imem_req_ready = 1'b1;
    hold = 1'b0;
    chk("rd3_occ", 64'(occupancy), 64'd0);
    chk("rd3_valid", 64'(out_valid), 64'd0);
    chk("rd3_addr", imem_req_addr, 64'h8000_1000);
    expect_head("rd3_h0", 64'h8000_1000);
    expect_head("rd3_h1", 64'h8000_1004);

    // redirect coinciding with a response and a ready head
    lat = 3;
    out_ready = 1'b1;
    found = 1'b0;
    for (int i = 0; i < 30; i++) begin
      @(negedge clk);
      if (out_valid && imem_rsp_valid) begin
        found = 1'b1;
        break;
      end
    end
    chk("rdx_setup", 64'(found), 64'd1);
    redirect_en = 1'b1;
    redirect_pc = 64'h8000_2000;
    @(negedge clk);
    redirect_en = 1'b0;
    out_ready = 1'b0;
    chk("rdx_occ", 64'(occupancy), 64'd0);
    chk("rdx_valid", 64'(out_valid), 64'd0);
    expect_head("rdx_h0", 64'h8000_2000);
    expect_head("rdx_h1", 64'h8000_2004);

    // PC wrap-around at the top of the address space
    lat = 1;
    redirect_en = 1'b1;
    redirect_pc = 64'hFFFF_FFFF_FFFF_FFFC;
    @(negedge clk);
    redirect_en = 1'b0;
    expect_head("wrap_h0", 64'hFFFF_FFFF_FFFF_FFFC);
    expect_head("wrap_h1", 64'h0);

    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end

endmodule
